// File: rtl/uart_rx_frame_check.sv
// Serial frame checker for the UART receive path.
// Takes majority-sampled bits one per strobe after a confirmed start bit. It assembles the
// data word LSB-first and accumulates parity serially. It then checks the optional parity
// bit and one or two stop bits, and reports the frame with sticky flags and saturating
// error counters.
// Ports:
//   CLK, RST        clock, asynchronous active-low reset
//   frame_start     start bit confirmed; the next strobe is data bit 0 (aborts any frame)
//   bit_valid       strobe qualifying sampled_bit
//   sampled_bit     sampled line value
//   PAR_EN/PAR_TYP  parity enable / type (even, odd, mark, space), latched on frame_start
//   STOP2           two stop bits expected, latched on frame_start
//   cnt_clr         synchronous clear of both error counters (wins over increment)
//   P_DATA          received word, updated on completion and held
//   frame_done      one-cycle completion pulse
//   par_err/stp_err error flags of the last completed frame
//   par_err_cnt/stp_err_cnt  saturating error-frame counters
module uart_rx_frame_check #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned CNT_WIDTH  = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  frame_start,
   input  logic                  bit_valid,
   input  logic                  sampled_bit,
   input  logic                  PAR_EN,
   input  logic [1:0]            PAR_TYP,
   input  logic                  STOP2,
   input  logic                  cnt_clr,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  frame_done,
   output logic                  par_err,
   output logic                  stp_err,
   output logic [CNT_WIDTH-1:0]  par_err_cnt,
   output logic [CNT_WIDTH-1:0]  stp_err_cnt
);

   localparam int unsigned BitCntW = $clog2(DATA_WIDTH + 1);

   typedef enum logic [2:0] {StIdle, StData, StParity, StStop1, StStop2} state_e;

   state_e                state_q, state_d;
   logic [BitCntW-1:0]    bit_cnt_q, bit_cnt_d;
   logic                  acc_q, acc_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  par_e_q, par_e_d;
   logic                  stp_e_q, stp_e_d;
   logic                  par_en_q, par_en_d;
   logic [1:0]            par_typ_q, par_typ_d;
   logic                  stop2_q, stop2_d;
   logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
   logic                  done_q, done_d;
   logic                  par_err_q, par_err_d;
   logic                  stp_err_q, stp_err_d;
   logic [CNT_WIDTH-1:0]  par_cnt_q, par_cnt_d;
   logic [CNT_WIDTH-1:0]  stp_cnt_q, stp_cnt_d;
   logic                  exp_par;
   logic                  complete;

   always_comb begin
      exp_par = 1'b0;
      unique case (par_typ_q)
         2'b00:   exp_par = acc_q;
         2'b01:   exp_par = ~acc_q;
         2'b10:   exp_par = 1'b1;
         default: exp_par = 1'b0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      acc_d     = acc_q;
      shift_d   = shift_q;
      par_e_d   = par_e_q;
      stp_e_d   = stp_e_q;
      par_en_d  = par_en_q;
      par_typ_d = par_typ_q;
      stop2_d   = stop2_q;
      p_data_d  = p_data_q;
      done_d    = 1'b0;
      par_err_d = par_err_q;
      stp_err_d = stp_err_q;
      par_cnt_d = par_cnt_q;
      stp_cnt_d = stp_cnt_q;
      complete  = 1'b0;

      if (frame_start) begin
         // Also the abort path: no completion, outputs untouched.
         state_d   = StData;
         bit_cnt_d = '0;
         acc_d     = 1'b0;
         shift_d   = '0;
         par_e_d   = 1'b0;
         stp_e_d   = 1'b0;
         par_en_d  = PAR_EN;
         par_typ_d = PAR_TYP;
         stop2_d   = STOP2;
      end else if (bit_valid) begin
         unique case (state_q)
            StIdle: ;
            StData: begin
               shift_d   = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
               acc_d     = acc_q ^ sampled_bit;
               bit_cnt_d = bit_cnt_q + BitCntW'(1);
               if (bit_cnt_q == BitCntW'(DATA_WIDTH - 1)) begin
                  state_d = par_en_q ? StParity : StStop1;
               end
            end
            StParity: begin
               if (sampled_bit != exp_par) par_e_d = 1'b1;
               state_d = StStop1;
            end
            StStop1: begin
               if (!sampled_bit) stp_e_d = 1'b1;
               if (stop2_q) state_d = StStop2;
               else         complete = 1'b1;
            end
            StStop2: begin
               if (!sampled_bit) stp_e_d = 1'b1;
               complete = 1'b1;
            end
            default: state_d = StIdle;
         endcase
      end

      if (complete) begin
         state_d   = StIdle;
         done_d    = 1'b1;
         p_data_d  = shift_q;
         par_err_d = par_en_q & par_e_d;
         stp_err_d = stp_e_d;
         if (par_err_d && par_cnt_q != '1) par_cnt_d = par_cnt_q + CNT_WIDTH'(1);
         if (stp_err_d && stp_cnt_q != '1) stp_cnt_d = stp_cnt_q + CNT_WIDTH'(1);
      end

      if (cnt_clr) begin
         par_cnt_d = '0;
         stp_cnt_d = '0;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= StIdle;
         bit_cnt_q <= '0;
         acc_q     <= 1'b0;
         shift_q   <= '0;
         par_e_q   <= 1'b0;
         stp_e_q   <= 1'b0;
         par_en_q  <= 1'b0;
         par_typ_q <= 2'b00;
         stop2_q   <= 1'b0;
         p_data_q  <= '0;
         done_q    <= 1'b0;
         par_err_q <= 1'b0;
         stp_err_q <= 1'b0;
         par_cnt_q <= '0;
         stp_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         acc_q     <= acc_d;
         shift_q   <= shift_d;
         par_e_q   <= par_e_d;
         stp_e_q   <= stp_e_d;
         par_en_q  <= par_en_d;
         par_typ_q <= par_typ_d;
         stop2_q   <= stop2_d;
         p_data_q  <= p_data_d;
         done_q    <= done_d;
         par_err_q <= par_err_d;
         stp_err_q <= stp_err_d;
         par_cnt_q <= par_cnt_d;
         stp_cnt_q <= stp_cnt_d;
      end
   end

   assign P_DATA      = p_data_q;
   assign frame_done  = done_q;
   assign par_err     = par_err_q;
   assign stp_err     = stp_err_q;
   assign par_err_cnt = par_cnt_q;
   assign stp_err_cnt = stp_cnt_q;

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Self-checking bench for uart_rx_frame_check: table of frame vectors plus hand-written
// sequences for abort, mid-frame reset, counter clear and counter saturation.
module tb_uart_rx_frame_check;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       frame_start = 1'b0;
   logic       bit_valid = 1'b0;
   logic       sampled_bit = 1'b0;
   logic       PAR_EN = 1'b0;
   logic [1:0] PAR_TYP = 2'b00;
   logic       STOP2 = 1'b0;
   logic       cnt_clr = 1'b0;
   logic [7:0] P_DATA;
   logic       frame_done;
   logic       par_err;
   logic       stp_err;
   logic [7:0] par_err_cnt;
   logic [7:0] stp_err_cnt;

   int checks = 0;
   int errors = 0;

   uart_rx_frame_check #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .frame_start (frame_start),
      .bit_valid   (bit_valid),
      .sampled_bit (sampled_bit),
      .PAR_EN      (PAR_EN),
      .PAR_TYP     (PAR_TYP),
      .STOP2       (STOP2),
      .cnt_clr     (cnt_clr),
      .P_DATA      (P_DATA),
      .frame_done  (frame_done),
      .par_err     (par_err),
      .stp_err     (stp_err),
      .par_err_cnt (par_err_cnt),
      .stp_err_cnt (stp_err_cnt)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [7:0] data;
      logic       pen;
      logic [1:0] typ;
      logic       s2;
      logic       pbit;
      logic       stop_a;
      logic       stop_b;
      logic       exp_pe;
      logic       exp_se;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drives one frame. Configuration inputs are inverted right after frame_start to show
   // they are latched. Returns just after the edge that samples the final bit, or after
   // abort_after data bits when abort_after >= 0. early counts frame_done seen too soon.
   task automatic send_frame(input logic [7:0] d, input logic pen, input logic [1:0] typ,
                             input logic s2, input logic pbit, input logic sa,
                             input logic sb, input logic clr_last, input int abort_after,
                             output int early);
      logic bits[$];
      early = 0;
      for (int i = 0; i < 8; i++) bits.push_back(d[i]);
      if (pen) bits.push_back(pbit);
      bits.push_back(sa);
      if (s2) bits.push_back(sb);
      @(negedge CLK);
      frame_start = 1'b1;
      PAR_EN      = pen;
      PAR_TYP     = typ;
      STOP2       = s2;
      @(posedge CLK);
      #1;
      frame_start = 1'b0;
      PAR_EN      = ~pen;
      PAR_TYP     = ~typ;
      STOP2       = ~s2;
      if (frame_done) early++;
      for (int i = 0; i < bits.size(); i++) begin
         if (abort_after >= 0 && i == abort_after) break;
         @(negedge CLK);
         bit_valid   = 1'b1;
         sampled_bit = bits[i];
         if (i == bits.size() - 1 && clr_last) cnt_clr = 1'b1;
         @(posedge CLK);
         #1;
         bit_valid = 1'b0;
         cnt_clr   = 1'b0;
         if (i != bits.size() - 1) begin
            if (frame_done) early++;
            @(posedge CLK);
            #1;
            if (frame_done) early++;
         end
      end
   endtask

   initial begin
      int early;
      int exp_pc;
      int exp_sc;
      exp_pc = 0;
      exp_sc = 0;

      //           data   pen   typ    s2    pbit  sa    sb    pe    se
      vecs[0] = '{8'hA5, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}; // 8N1
      vecs[1] = '{8'h07, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}; // 8E1 ok
      vecs[2] = '{8'h07, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0}; // 8O1 bad
      vecs[3] = '{8'h55, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0}; // mark, bit 0
      vecs[4] = '{8'h81, 1'b1, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}; // space, bit 0
      vecs[5] = '{8'hFF, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1}; // stops 1,0
      vecs[6] = '{8'h00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}; // stops 1,1
      vecs[7] = '{8'h3C, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1}; // stop 0
      vecs[8] = '{8'h01, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1}; // both errors

      #12;
      chk("rst_pdata", 32'(P_DATA), 32'h0);
      chk("rst_done", 32'(frame_done), 32'h0);
      chk("rst_flags", 32'({par_err, stp_err}), 32'h0);
      chk("rst_cnts", 32'({par_err_cnt, stp_err_cnt}), 32'h0);
      @(negedge CLK);
      RST = 1'b1;

      // A strobe while idle must be ignored.
      @(negedge CLK);
      bit_valid = 1'b1;
      @(posedge CLK);
      #1;
      bit_valid = 1'b0;
      chk("idle_strobe_done", 32'(frame_done), 32'h0);

      for (int i = 0; i < 9; i++) begin
         send_frame(vecs[i].data, vecs[i].pen, vecs[i].typ, vecs[i].s2, vecs[i].pbit,
                    vecs[i].stop_a, vecs[i].stop_b, 1'b0, -1, early);
         if (vecs[i].exp_pe) exp_pc++;
         if (vecs[i].exp_se) exp_sc++;
         chk($sformatf("v%0d_early", i), 32'(early), 32'h0);
         chk($sformatf("v%0d_done", i), 32'(frame_done), 32'h1);
         chk($sformatf("v%0d_pdata", i), 32'(P_DATA), 32'(vecs[i].data));
         chk($sformatf("v%0d_par_err", i), 32'(par_err), 32'(vecs[i].exp_pe));
         chk($sformatf("v%0d_stp_err", i), 32'(stp_err), 32'(vecs[i].exp_se));
         chk($sformatf("v%0d_par_cnt", i), 32'(par_err_cnt), 32'(exp_pc));
         chk($sformatf("v%0d_stp_cnt", i), 32'(stp_err_cnt), 32'(exp_sc));
         @(posedge CLK);
         #1;
         chk($sformatf("v%0d_done_pulse", i), 32'(frame_done), 32'h0);
         chk($sformatf("v%0d_pdata_hold", i), 32'(P_DATA), 32'(vecs[i].data));
      end

      // Abort after 3 data bits: outputs untouched, then a clean 0x3C frame.
      send_frame(8'h5A, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3, early);
      chk("abort_early", 32'(early), 32'h0);
      send_frame(8'h3C, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1, early);
      chk("abort_no_done", 32'(early), 32'h0);
      chk("after_abort_done", 32'(frame_done), 32'h1);
      chk("after_abort_pdata", 32'(P_DATA), 32'h3C);
      chk("after_abort_flags", 32'({par_err, stp_err}), 32'h0);
      chk("after_abort_par_cnt", 32'(par_err_cnt), 32'(exp_pc));
      chk("after_abort_stp_cnt", 32'(stp_err_cnt), 32'(exp_sc));

      // Standalone counter clear.
      @(negedge CLK);
      cnt_clr = 1'b1;
      @(posedge CLK);
      #1;
      cnt_clr = 1'b0;
      chk("clr_par_cnt", 32'(par_err_cnt), 32'h0);
      chk("clr_stp_cnt", 32'(stp_err_cnt), 32'h0);
      chk("clr_pdata_kept", 32'(P_DATA), 32'h3C);

      // Reset in the middle of a frame.
      send_frame(8'hF0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4, early);
      RST = 1'b0;
      #2;
      chk("midrst_pdata", 32'(P_DATA), 32'h0);
      chk("midrst_done", 32'(frame_done), 32'h0);
      @(negedge CLK);
      RST = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK);
         bit_valid   = 1'b1;
         sampled_bit = 1'b1;
         @(posedge CLK);
         #1;
         bit_valid = 1'b0;
         if (frame_done) early++;
      end
      chk("midrst_no_done", 32'(early), 32'h0);
      send_frame(8'h96, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1, early);
      chk("postrst_done", 32'(frame_done), 32'h1);
      chk("postrst_pdata", 32'(P_DATA), 32'h96);
      chk("postrst_flags", 32'({par_err, stp_err}), 32'h0);

      // Saturation: 258 parity-error frames (8O1, 0x07, parity bit 1).
      for (int k = 1; k <= 258; k++) begin
         send_frame(8'h07, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, -1, early);
         if (k == 255) chk("sat_at_255", 32'(par_err_cnt), 32'd255);
      end
      chk("sat_par_cnt", 32'(par_err_cnt), 32'd255);
      chk("sat_par_err", 32'(par_err), 32'h1);
      chk("sat_stp_cnt", 32'(stp_err_cnt), 32'h0);

      // Clear coincident with an increment wins.
      send_frame(8'h07, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, -1, early);
      chk("clr_vs_inc_done", 32'(frame_done), 32'h1);
      chk("clr_vs_inc_cnt", 32'(par_err_cnt), 32'h0);
      chk("clr_vs_inc_flag", 32'(par_err), 32'h1);
      send_frame(8'h07, 1'b1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, -1, early);
      chk("inc_after_clr", 32'(par_err_cnt), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
